// File: rtl/gci_std_display_pixel_buffer.sv
// Display pixel FIFO between the frame fetcher and the timing generator.
// It prefills each frame, streams on request, and flags underruns.
module gci_std_display_pixel_buffer #(
   parameter int unsigned             P_DATA_WIDTH     = 16,
   parameter int unsigned             P_DEPTH_N        = 6,
   parameter int unsigned             P_PREFILL        = 32,
   parameter logic [P_DATA_WIDTH-1:0] P_UNDERRUN_COLOR = '1
)(
   input  logic                    iDISP_CLOCK,
   input  logic                    inRESET,
   input  logic                    iRESET_SYNC,
   input  logic                    iWR_VALID,
   input  logic [P_DATA_WIDTH-1:0] iWR_DATA,
   output logic                    oWR_READY,
   output logic                    oFRAME_START,
   input  logic                    iDATA_REQ,
   input  logic                    iDATA_SYNC,
   input  logic                    inDISP_HSYNC,
   input  logic                    inDISP_VSYNC,
   output logic [P_DATA_WIDTH-1:0] oDISP_DATA,
   output logic                    oDISP_ENA,
   output logic                    onDISP_HSYNC,
   output logic                    onDISP_VSYNC,
   output logic                    oUNDERRUN
);

   localparam int unsigned            DEPTH_C       = 1 << P_DEPTH_N;
   localparam logic [P_DEPTH_N:0]     DEPTH_CNT_C   = (P_DEPTH_N + 1)'(DEPTH_C);
   localparam logic [P_DEPTH_N:0]     PREFILL_CNT_C = (P_DEPTH_N + 1)'(P_PREFILL);
   localparam logic [P_DEPTH_N:0]     CNT_ONE_C     = (P_DEPTH_N + 1)'(1);
   localparam logic [P_DEPTH_N-1:0]   PTR_ONE_C     = P_DEPTH_N'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [P_DEPTH_N:0]      count_r;
   logic [P_DEPTH_N:0]      count_nxt_s;
   logic [P_DEPTH_N-1:0]    wr_ptr_r;
   logic [P_DEPTH_N-1:0]    rd_ptr_r;
   logic [P_DATA_WIDTH-1:0] mem_r [DEPTH_C];

   logic                    sync_d_r;
   logic                    sync_edge_s;
   logic                    wr_ready_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    underrun_hit_s;

   logic [P_DATA_WIDTH-1:0] data_r;
   logic [P_DATA_WIDTH-1:0] data_nxt_s;
   logic                    ena_r;
   logic                    hsync_r;
   logic                    vsync_r;
   logic                    underrun_r;
   logic                    underrun_nxt_s;
   logic                    frame_start_r;

   // A rising iDATA_SYNC is the only frame boundary; it overrides pushes and pops.
   assign sync_edge_s    = iDATA_SYNC & ~sync_d_r;
   assign wr_ready_s     = inRESET & ~iRESET_SYNC & (state_r != ST_IDLE)
                           & (count_r < DEPTH_CNT_C) & ~sync_edge_s;
   assign push_s         = iWR_VALID & wr_ready_s;
   assign pop_s          = (state_r == ST_STREAM) & iDATA_REQ
                           & (count_r != '0) & ~sync_edge_s;
   assign underrun_hit_s = (state_r == ST_STREAM) & iDATA_REQ
                           & (count_r == '0) & ~sync_edge_s;

   // Next-state decode for the frame state machine.
   always_comb begin
      state_nxt_s = state_r;
      if (sync_edge_s) begin
         state_nxt_s = ST_FILL;
      end else begin
         case (state_r)
            ST_IDLE:   state_nxt_s = ST_IDLE;
            ST_FILL:   state_nxt_s = (count_r >= PREFILL_CNT_C) ? ST_STREAM : ST_FILL;
            ST_STREAM: state_nxt_s = underrun_hit_s ? ST_ERROR : ST_STREAM;
            ST_ERROR:  state_nxt_s = ST_ERROR;
            default:   state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Occupancy update; simultaneous push and pop cancel out.
   always_comb begin
      count_nxt_s = count_r;
      if (sync_edge_s) begin
         count_nxt_s = '0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
         endcase
      end
   end

   // Pixel selection: a popped word, the underrun colour, or black.
   always_comb begin
      data_nxt_s = '0;
      if (sync_edge_s) begin
         data_nxt_s = '0;
      end else if (pop_s) begin
         data_nxt_s = mem_r[rd_ptr_r];
      end else if (iDATA_REQ & ((state_r == ST_STREAM) | (state_r == ST_ERROR))) begin
         data_nxt_s = P_UNDERRUN_COLOR;
      end else begin
         data_nxt_s = '0;
      end
   end

   // Underrun flag is sticky for the rest of the frame.
   always_comb begin
      underrun_nxt_s = underrun_r;
      if (sync_edge_s) begin
         underrun_nxt_s = 1'b0;
      end else if (underrun_hit_s) begin
         underrun_nxt_s = 1'b1;
      end else begin
         underrun_nxt_s = underrun_r;
      end
   end

   // Control state, pointers and registered panel outputs.
   always_ff @(posedge iDISP_CLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_r       <= ST_IDLE;
         count_r       <= '0;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         sync_d_r      <= 1'b0;
         data_r        <= '0;
         ena_r         <= 1'b0;
         hsync_r       <= 1'b1;
         vsync_r       <= 1'b1;
         underrun_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else if (iRESET_SYNC) begin
         state_r       <= ST_IDLE;
         count_r       <= '0;
         wr_ptr_r      <= '0;
         rd_ptr_r      <= '0;
         sync_d_r      <= 1'b0;
         data_r        <= '0;
         ena_r         <= 1'b0;
         hsync_r       <= 1'b1;
         vsync_r       <= 1'b1;
         underrun_r    <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         count_r       <= count_nxt_s;
         sync_d_r      <= iDATA_SYNC;
         data_r        <= data_nxt_s;
         ena_r         <= iDATA_REQ;
         hsync_r       <= inDISP_HSYNC;
         vsync_r       <= inDISP_VSYNC;
         underrun_r    <= underrun_nxt_s;
         frame_start_r <= sync_edge_s;
         if (sync_edge_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
         end
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge iDISP_CLOCK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= iWR_DATA;
      end
   end

   assign oWR_READY    = wr_ready_s;
   assign oFRAME_START = frame_start_r;
   assign oDISP_DATA   = data_r;
   assign oDISP_ENA    = ena_r;
   assign onDISP_HSYNC = hsync_r;
   assign onDISP_VSYNC = vsync_r;
   assign oUNDERRUN    = underrun_r;

endmodule

// File: doc/gci_std_display_pixel_buffer.md
GCI_STD_DISPLAY_PIXEL_BUFFER -- requirements
Module: gci_std_display_pixel_buffer

Interface
REQ-001 Parameter P_DATA_WIDTH, default 16: pixel word width.
REQ-002 Parameter P_DEPTH_N, default 6: the FIFO holds 2^P_DEPTH_N words.
REQ-003 Parameter P_PREFILL, default 32: FIFO occupancy needed to start streaming; legal range 1..2^P_DEPTH_N.
REQ-004 Parameter P_UNDERRUN_COLOR, default all-ones: pixel value output on underrun.
REQ-005 iDISP_CLOCK  in  1: pixel clock; all logic is on its rising edge.
REQ-006 inRESET  in  1: asynchronous, active-low reset.
REQ-007 iRESET_SYNC  in  1: synchronous reset, same effect as inRESET.
REQ-008 iWR_VALID / iWR_DATA  in  1 / P_DATA_WIDTH: pixel write from the memory fetcher.
REQ-009 oWR_READY  out  1: write accepted on a cycle where iWR_VALID and oWR_READY are both 1.
REQ-010 oFRAME_START  out  1: one-cycle pulse telling the fetcher to restart at the frame base address.
REQ-011 iDATA_REQ  in  1: pixel pop request from the timing generator (active area).
REQ-012 iDATA_SYNC  in  1: level from the timing generator, high during the last line of a frame.
REQ-013 inDISP_HSYNC / inDISP_VSYNC  in  1 / 1: active-low syncs from the timing generator.
REQ-014 oDISP_DATA  out  P_DATA_WIDTH: registered pixel.
REQ-015 oDISP_ENA  out  1: registered data-valid for the panel.
REQ-016 onDISP_HSYNC / onDISP_VSYNC  out  1 / 1: the sync inputs delayed by one cycle.
REQ-017 oUNDERRUN  out  1: sticky underrun flag for the current frame.

Function
REQ-018 The sync edge, sync_edge = iDATA_SYNC & !(iDATA_SYNC registered one cycle earlier), SHALL be the only frame-boundary event.
REQ-019 State machine: IDLE, FILL, STREAM, ERROR.
- IDLE SHALL go to FILL on sync_edge.
- FILL SHALL go to STREAM when count >= P_PREFILL.
- STREAM SHALL go to ERROR when iDATA_REQ is 1 and count is 0.
- From any state, sync_edge SHALL go to FILL.
REQ-020 On sync_edge the FIFO SHALL be flushed (count=0, pointers=0) and oFRAME_START SHALL be 1 in the next cycle only; oUNDERRUN SHALL clear in the same cycle.
REQ-021 oWR_READY SHALL be combinational: (state != IDLE) & (count < 2^P_DEPTH_N) & !sync_edge.
REQ-022 The FIFO SHALL pop only when state is STREAM, iDATA_REQ is 1 and count > 0; the popped word appears on oDISP_DATA the next cycle (latency 1).
REQ-023 iDATA_REQ with no pop SHALL output the following on the next cycle:
- P_UNDERRUN_COLOR in STREAM (count 0) and in ERROR;
- zero in FILL and IDLE.
REQ-024 oUNDERRUN SHALL set in the cycle after the STREAM-to-ERROR transition and hold until the next sync_edge.
REQ-025 In ERROR no pops occur, and writes are still accepted until full.
REQ-026 A push and pop in the same cycle SHALL leave count unchanged.
REQ-027 When full, a same-cycle pop does not enable a write (oWR_READY stays 0).
REQ-028 When empty, a same-cycle push does not bypass to the output (underrun rule applies).
REQ-029 count SHALL be P_DEPTH_N+1 bits wide, and pointers SHALL be P_DEPTH_N bits and wrap modulo 2^P_DEPTH_N.
REQ-030 oDISP_ENA, onDISP_HSYNC and onDISP_VSYNC SHALL equal iDATA_REQ, inDISP_HSYNC and inDISP_VSYNC delayed exactly one cycle, aligned with oDISP_DATA.
REQ-031 sync_edge coinciding with a write SHALL discard the write.
REQ-032 sync_edge coinciding with iDATA_REQ SHALL not pop, and the next-cycle pixel follows the new state's rule (FILL gives zero).

Reset
REQ-033 On inRESET low (async) or iRESET_SYNC high (sync), the block SHALL take these values:
- state IDLE, count and pointers 0, sync register 0;
- oDISP_DATA 0, oDISP_ENA 0;
- onDISP_HSYNC 1, onDISP_VSYNC 1;
- oUNDERRUN 0, oFRAME_START 0.
REQ-034 While in reset oWR_READY SHALL be 0.
REQ-035 FIFO storage contents need not be reset.

Verification (P_DEPTH_N=4, P_PREFILL=8, P_DATA_WIDTH=16)
REQ-036 Reset, then hold iDATA_SYNC 0 and iWR_VALID 1 -> oWR_READY stays 0, state stays IDLE.
REQ-037 Raise iDATA_SYNC, then write 0x0001..0x0010 -> the following SHALL hold:
- oFRAME_START pulses once, one cycle after the edge;
- oWR_READY drops after 16 writes;
- STREAM is entered when count reaches 8.
REQ-038 In STREAM, iDATA_REQ high for 16 cycles with no writes -> oDISP_DATA = 0x0001..0x0010 one cycle later, with oDISP_ENA aligned.
REQ-039 Continue iDATA_REQ after 16 pops -> the following SHALL hold:
- oDISP_DATA = 0xFFFF;
- oUNDERRUN = 1 and holds;
- later writes are not popped until the next sync_edge.
REQ-040 Full FIFO, pop and iWR_VALID in the same cycle -> no write accepted and count goes to 15.
REQ-041 Rising iDATA_SYNC with 5 words stored and iWR_VALID 1 -> the following SHALL hold:
- count goes to 0 and the write is dropped;
- oUNDERRUN clears;
- asserting inRESET mid-stream then returns all outputs to their reset values asynchronously.
